// File: rtl/pinball_game_sequencer.sv
// pinball_game_sequencer
// Frame-level game flow for the pinball datapath. Per-pixel overlap flags
// are collected into latches during a frame and qualified into at most one
// event per frame on startOfFrame (bottom beats flipper beats border).
// An FSM runs idle/launch/play/lost/over and maintains lives and a BCD score.
module pinball_game_sequencer #(
  parameter int LIVES         = 3,
  parameter int LAUNCH_FRAMES = 60,
  parameter int LOST_FRAMES   = 90,
  parameter int FLIP_COOLDOWN = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        draw_smiley,
  input  logic        draw_boarders,
  input  logic        draw_bottom_boarder,
  input  logic        draw_flipper,
  input  logic        key_start,
  output logic        hitBorders,
  output logic        hitFlipper,
  output logic        freeze,
  output logic        ball_reset,
  output logic        game_over,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_PLAY   = 3'd2,
    S_LOST   = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [2:0]  LIVES_INIT  = 3'(LIVES);
  localparam logic [15:0] LAUNCH_LAST = 16'(LAUNCH_FRAMES - 1);
  localparam logic [15:0] LOST_LAST   = 16'(LOST_FRAMES - 1);
  localparam logic [7:0]  COOL_INIT   = 8'(FLIP_COOLDOWN);

  // BCD increment with ripple carry; 9999 is a ceiling, never wraps.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      res = v;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (v[4*d +: 4] == 4'd9) begin
            res[4*d +: 4] = 4'd0;
            carry         = 1'b1;
          end else begin
            res[4*d +: 4] = v[4*d +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end else begin
          res[4*d +: 4] = v[4*d +: 4];
        end
      end
    end
    return res;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic        r_key_prev;
  logic        w_start;
  logic        w_play;
  logic        w_new_game;
  logic        w_ovl_bord;
  logic        w_ovl_flip;
  logic        w_ovl_bot;
  logic        r_lat_bord;
  logic        r_lat_flip;
  logic        r_lat_bot;
  logic        r_hit_bord;
  logic        r_hit_flip;
  logic        r_ev_bot;
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_cooldown;
  logic [2:0]  r_lives;
  logic [15:0] r_score;
  logic        r_freeze;
  logic        r_ball_reset;
  logic        r_game_over;

  assign w_play     = (r_state == S_PLAY);
  assign w_start    = key_start & ~r_key_prev;
  assign w_new_game = w_start & ((r_state == S_IDLE) | (r_state == S_OVER));
  assign w_ovl_bord = draw_smiley & draw_boarders;
  assign w_ovl_flip = draw_smiley & draw_flipper;
  assign w_ovl_bot  = draw_smiley & draw_bottom_boarder;

  // Previous key sample; resets high so a key held through reset is not a start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_key_prev <= 1'b1;
    end else begin
      r_key_prev <= key_start;
    end
  end

  // Per-frame collision latches; an overlap on the startOfFrame cycle seeds the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lat_bord <= 1'b0;
      r_lat_flip <= 1'b0;
      r_lat_bot  <= 1'b0;
    end else if (!w_play) begin
      r_lat_bord <= 1'b0;
      r_lat_flip <= 1'b0;
      r_lat_bot  <= 1'b0;
    end else if (startOfFrame) begin
      r_lat_bord <= w_ovl_bord;
      r_lat_flip <= w_ovl_flip;
      r_lat_bot  <= w_ovl_bot;
    end else begin
      r_lat_bord <= r_lat_bord | w_ovl_bord;
      r_lat_flip <= r_lat_flip | w_ovl_flip;
      r_lat_bot  <= r_lat_bot  | w_ovl_bot;
    end
  end

  // Qualified one-cycle frame events with bottom > flipper > border priority.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ev_bot   <= 1'b0;
      r_hit_flip <= 1'b0;
      r_hit_bord <= 1'b0;
    end else begin
      r_ev_bot   <= startOfFrame & w_play & r_lat_bot;
      r_hit_flip <= startOfFrame & w_play & r_lat_flip & ~r_lat_bot
                    & (r_cooldown == 8'd0);
      r_hit_bord <= startOfFrame & w_play & r_lat_bord & ~r_lat_flip & ~r_lat_bot;
    end
  end

  // Flipper cooldown: reload on a scored hit, otherwise count frames down to zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cooldown <= 8'd0;
    end else if (r_hit_flip) begin
      r_cooldown <= COOL_INIT;
    end else if (startOfFrame && (r_cooldown != 8'd0)) begin
      r_cooldown <= r_cooldown - 8'd1;
    end else begin
      r_cooldown <= r_cooldown;
    end
  end

  // Game state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the game flow.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_LAUNCH;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LAUNCH: begin
        if (startOfFrame && (r_frame_cnt == LAUNCH_LAST)) begin
          w_state_next = S_PLAY;
        end else begin
          w_state_next = S_LAUNCH;
        end
      end
      S_PLAY: begin
        if (r_ev_bot) begin
          w_state_next = S_LOST;
        end else begin
          w_state_next = S_PLAY;
        end
      end
      S_LOST: begin
        if (startOfFrame && (r_frame_cnt == LOST_LAST)) begin
          if (r_lives == 3'd0) begin
            w_state_next = S_OVER;
          end else begin
            w_state_next = S_LAUNCH;
          end
        end else begin
          w_state_next = S_LOST;
        end
      end
      S_OVER: begin
        if (w_start) begin
          w_state_next = S_LAUNCH;
        end else begin
          w_state_next = S_OVER;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Frame counter, restarted on every state change.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frame_cnt <= 16'd0;
    end else if (w_state_next != r_state) begin
      r_frame_cnt <= 16'd0;
    end else if (startOfFrame) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

  // Lives: reload on a new game, lose one (saturating) on a bottom event.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lives <= LIVES_INIT;
    end else if (w_new_game) begin
      r_lives <= LIVES_INIT;
    end else if (r_ev_bot && w_play && (r_lives != 3'd0)) begin
      r_lives <= r_lives - 3'd1;
    end else begin
      r_lives <= r_lives;
    end
  end

  // Score: clear on a new game, BCD +1 on each scored flipper hit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_score <= 16'h0000;
    end else if (w_new_game) begin
      r_score <= 16'h0000;
    end else if (r_hit_flip) begin
      r_score <= bcd_inc(r_score);
    end else begin
      r_score <= r_score;
    end
  end

  // State-decoded control outputs, registered alongside the state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_freeze     <= 1'b1;
      r_ball_reset <= 1'b1;
      r_game_over  <= 1'b0;
    end else begin
      r_freeze     <= (w_state_next != S_PLAY);
      r_ball_reset <= (w_state_next == S_IDLE) | (w_state_next == S_LAUNCH)
                      | (w_state_next == S_OVER);
      r_game_over  <= (w_state_next == S_OVER);
    end
  end

  assign hitBorders = r_hit_bord;
  assign hitFlipper = r_hit_flip;
  assign freeze     = r_freeze;
  assign ball_reset = r_ball_reset;
  assign game_over  = r_game_over;
  assign lives      = r_lives;
  assign score      = r_score;
  assign state      = r_state;

endmodule

// File: tb/tb_pinball_game_sequencer.sv
// Directed bench for pinball_game_sequencer: a default-parameter instance for
// the game flow and a fast instance (1-frame launch, no cooldown) for score
// carry and saturation.
module tb_pinball_game_sequencer;

  logic clk;
  logic resetN;
  logic sof, smiley, bord, bot, flip, key;
  logic hit_b, hit_f, frz, brst, gover;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [2:0]  state;

  logic resetN2;
  logic sof2, smiley2, flip2, key2;
  logic hit_b2, hit_f2, frz2, brst2, gover2;
  logic [2:0]  lives2;
  logic [15:0] score2;
  logic [2:0]  state2;

  int total = 0;
  int bad   = 0;
  logic found;

  pinball_game_sequencer u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_smiley(smiley),
    .draw_boarders(bord), .draw_bottom_boarder(bot), .draw_flipper(flip),
    .key_start(key), .hitBorders(hit_b), .hitFlipper(hit_f), .freeze(frz),
    .ball_reset(brst), .game_over(gover), .lives(lives), .score(score),
    .state(state)
  );

  pinball_game_sequencer #(
    .LIVES(1), .LAUNCH_FRAMES(1), .LOST_FRAMES(1), .FLIP_COOLDOWN(0)
  ) u_sat (
    .clk(clk), .resetN(resetN2), .startOfFrame(sof2), .draw_smiley(smiley2),
    .draw_boarders(1'b0), .draw_bottom_boarder(1'b0), .draw_flipper(flip2),
    .key_start(key2), .hitBorders(hit_b2), .hitFlipper(hit_f2), .freeze(frz2),
    .ball_reset(brst2), .game_over(gover2), .lives(lives2), .score(score2),
    .state(state2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // one-cycle startOfFrame; returns at T+1
  task automatic sof_cycle();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic empty_frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof_cycle();
      tick(2);
    end
  endtask

  task automatic overlap(input logic b, input logic f, input logic bt, input int n);
    smiley = 1'b1;
    bord = b;
    flip = f;
    bot = bt;
    tick(n);
    smiley = 1'b0;
    bord = 1'b0;
    flip = 1'b0;
    bot = 1'b0;
  endtask

  task automatic launch_to_play();
    empty_frames(59);
    check("launch_hold", 32'(state), 32'd1);
    sof_cycle();
    check("launch_to_play", 32'(state), 32'd2);
  endtask

  task automatic lose_ball();
    tick(1);
    overlap(1'b0, 1'b0, 1'b1, 2);
    sof_cycle();
    tick(1);
  endtask

  task automatic lost_period();
    empty_frames(89);
    check("lost_hold", 32'(state), 32'd3);
    sof_cycle();
  endtask

  initial begin
    resetN = 1'b0; sof = 1'b0; smiley = 1'b0; bord = 1'b0; bot = 1'b0;
    flip = 1'b0; key = 1'b0;
    resetN2 = 1'b0; sof2 = 1'b0; smiley2 = 1'b0; flip2 = 1'b0; key2 = 1'b0;
    tick(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_freeze", 32'(frz), 32'd1);
    check("rst_ball_reset", 32'(brst), 32'd1);
    check("rst_game_over", 32'(gover), 32'd0);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_score", 32'(score), 32'd0);
    check("rst_hits", 32'({hit_b, hit_f}), 32'd0);
    resetN = 1'b1;
    tick(2);

    // start game
    key = 1'b1;
    tick(1);
    check("start_launch", 32'(state), 32'd1);
    check("start_ball_reset", 32'(brst), 32'd1);
    key = 1'b0;
    launch_to_play();
    check("play_freeze", 32'(frz), 32'd0);
    check("play_ball_reset", 32'(brst), 32'd0);

    // scored flipper hit
    tick(1);
    overlap(1'b0, 1'b1, 1'b0, 5);
    sof_cycle();
    check("flip_pulse", 32'(hit_f), 32'd1);
    check("flip_no_bord", 32'(hit_b), 32'd0);
    check("flip_score_not_yet", 32'(score), 32'h0000);
    tick(1);
    check("flip_pulse_end", 32'(hit_f), 32'd0);
    check("flip_score", 32'(score), 32'h0001);

    // repeat hit inside cooldown
    tick(1);
    empty_frames(2);
    overlap(1'b0, 1'b1, 1'b0, 5);
    sof_cycle();
    check("cool_no_pulse", 32'(hit_f), 32'd0);
    tick(1);
    check("cool_score", 32'(score), 32'h0001);

    // plain border hit
    tick(1);
    overlap(1'b1, 1'b0, 1'b0, 3);
    sof_cycle();
    check("bord_pulse", 32'(hit_b), 32'd1);
    check("bord_no_flip", 32'(hit_f), 32'd0);
    tick(1);
    check("bord_pulse_end", 32'(hit_b), 32'd0);

    // cooldown expired; bottom overrides flipper and border
    empty_frames(5);
    overlap(1'b1, 1'b1, 1'b1, 4);
    sof_cycle();
    check("prio_no_flip", 32'(hit_f), 32'd0);
    check("prio_no_bord", 32'(hit_b), 32'd0);
    tick(1);
    check("lost_state", 32'(state), 32'd3);
    check("lost_lives", 32'(lives), 32'd2);
    check("lost_freeze", 32'(frz), 32'd1);
    check("lost_ball_reset", 32'(brst), 32'd0);
    check("lost_score", 32'(score), 32'h0001);
    lost_period();
    check("lost_to_launch", 32'(state), 32'd1);
    check("relaunch_lives", 32'(lives), 32'd2);

    // lose the remaining two balls
    launch_to_play();
    lose_ball();
    check("ball2_lives", 32'(lives), 32'd1);
    lost_period();
    check("ball2_relaunch", 32'(state), 32'd1);
    launch_to_play();
    lose_ball();
    check("ball3_lives", 32'(lives), 32'd0);
    lost_period();
    check("over_state", 32'(state), 32'd4);
    check("over_game_over", 32'(gover), 32'd1);
    check("over_lives", 32'(lives), 32'd0);
    check("over_ball_reset", 32'(brst), 32'd1);

    // restart from OVER
    tick(1);
    key = 1'b1;
    tick(1);
    check("restart_state", 32'(state), 32'd1);
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_score", 32'(score), 32'h0000);
    check("restart_game_over", 32'(gover), 32'd0);
    key = 1'b0;
    tick(1);

    // key held across reset release
    key = 1'b1;
    resetN = 1'b0;
    tick(2);
    resetN = 1'b1;
    tick(3);
    check("held_key_idle", 32'(state), 32'd0);
    key = 1'b0;
    tick(2);
    key = 1'b1;
    tick(1);
    check("repress_launch", 32'(state), 32'd1);
    key = 1'b0;
    launch_to_play();
    lose_ball();
    check("pre_rst_lost", 32'(state), 32'd3);
    empty_frames(10);

    // asynchronous reset in LOST
    resetN = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_lives", 32'(lives), 32'd3);
    check("async_rst_freeze", 32'(frz), 32'd1);
    @(negedge clk);
    resetN = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (hit_b || hit_f) found = 1'b1;
    end
    check("post_rst_no_pulse", 32'(found), 32'd0);
    check("post_rst_idle", 32'(state), 32'd0);

    // fast instance: score carry and saturation
    resetN2 = 1'b1;
    tick(1);
    key2 = 1'b1;
    tick(1);
    check("sat_launch", 32'(state2), 32'd1);
    smiley2 = 1'b1;
    flip2 = 1'b1;
    sof2 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (score2 == 16'h0999) begin
        found = 1'b1;
        break;
      end
    end
    check("sat_reach_0999", 32'(found), 32'd1);
    tick(1);
    check("sat_carry_1000", 32'(score2), 32'h1000);
    found = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (score2 == 16'h9999) begin
        found = 1'b1;
        break;
      end
    end
    check("sat_reach_9999", 32'(found), 32'd1);
    tick(5);
    check("sat_hold_9999", 32'(score2), 32'h9999);
    check("sat_still_hitting", 32'(hit_f2), 32'd1);
    check("sat_play", 32'(state2), 32'd2);
    check("sat_outputs", 32'({hit_b2, frz2, brst2, gover2, lives2}), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
